// File: rtl/tube_scroll_if.sv
// ----------------------------------------------------------------------------
// tube_scroll_if
//   Groups the tube_scroll controls and display outputs into one bundle.
//   Clock and reset stay plain ports on the design.
//
//   Signals
//     SW1       fast-speed select (highest priority)
//     SW2       impossible-speed select (ignored when SW1=1)
//     start     single-cycle restart request
//     col_in    new tube column, bit r = row r
//     bird_row  bird row, 0 = bottom, 15 = top
//     grid_o    16x16 display, bit (16*r + c) = row r, column c
//     line_o    top row (row 15), bit c = column c
//     tick_o    one-cycle pulse per scroll step
//     game_over high while the game is over
//     score     tubes passed
//
//   Modports
//     master  drives the controls, observes the display (generator / bench)
//     slave   the scroller itself
// ----------------------------------------------------------------------------
interface tube_scroll_if;
    logic         SW1;
    logic         SW2;
    logic         start;
    logic [15:0]  col_in;
    logic [3:0]   bird_row;
    logic [255:0] grid_o;
    logic [15:0]  line_o;
    logic         tick_o;
    logic         game_over;
    logic [7:0]   score;

    modport master (
        output SW1, SW2, start, col_in, bird_row,
        input  grid_o, line_o, tick_o, game_over, score
    );

    modport slave (
        input  SW1, SW2, start, col_in, bird_row,
        output grid_o, line_o, tick_o, game_over, score
    );
endinterface

// File: rtl/tube_scroll.sv
// ----------------------------------------------------------------------------
// tube_scroll
//   Scrolls a 16x16 tube grid one column per step toward the high column
//   index, loading a fresh column at column 0 on each step. A bird sits at
//   the fixed column BIRD_COL; hitting a lit cell ends the game, passing a
//   tube scores a point. Step rate is selected by SW1/SW2.
//
//   Ports
//     clk      sole clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      tube_scroll_if.slave (controls in, display/status out)
//
//   Optional feature
//     TUBE_SCORE_EN  defined: 8-bit saturating score counter is built.
//                    undefined: score is tied to 0, no score register.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | counting cycles, scrolling on each tick, checking the bird
//   OVER  | bird hit a tube; grid, counter and score frozen until start
// ----------------------------------------------------------------------------
module tube_scroll #(
    parameter int TICK_NORM = 8,
    parameter int TICK_FAST = 4,
    parameter int TICK_IMP  = 2,
    parameter int BIRD_COL  = 12
) (
    input  logic         clk,
    input  logic         reset_n,
    tube_scroll_if.slave bus
);

    localparam logic [0:0]  ST_RUN  = 1'b0;
    localparam logic [0:0]  ST_OVER = 1'b1;

    localparam logic [23:0] PER_NORM_M1 = 24'(TICK_NORM - 1);
    localparam logic [23:0] PER_FAST_M1 = 24'(TICK_FAST - 1);
    localparam logic [23:0] PER_IMP_M1  = 24'(TICK_IMP - 1);
    localparam logic [3:0]  BIRD_C      = 4'(BIRD_COL);

    logic [0:0]   state_q, state_d;
    logic [23:0]  cnt_q, cnt_d;
    logic [255:0] grid_q, grid_d;
    logic         tick_q, tick_d;

    logic [23:0]  period_m1;
    logic         in_run;
    logic         tick_due;
    logic         collide;

    // Speed select is combinational so a change applies to the running count.
    always_comb begin
        period_m1 = PER_NORM_M1;
        if (bus.SW1) begin
            period_m1 = PER_FAST_M1;
        end else if (bus.SW2) begin
            period_m1 = PER_IMP_M1;
        end
    end

    assign in_run   = (state_q == ST_RUN);
    assign tick_due = in_run && (cnt_q >= period_m1);
    // {row, col} is exactly the flat index 16*row + col.
    assign collide  = in_run && grid_q[{bus.bird_row, BIRD_C}];

    // A collision freezes everything at that edge, so the grid shown in OVER
    // is the one the bird actually hit and no tick pulse leaks into OVER.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grid_d  = grid_q;
        tick_d  = 1'b0;
        if (bus.start) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            grid_d  = '0;
        end else if (in_run) begin
            if (collide) begin
                state_d = ST_OVER;
            end else if (tick_due) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                for (int r = 0; r < 16; r++) begin
                    grid_d[16*r +: 16] = {grid_q[16*r +: 15], bus.col_in[r]};
                end
            end else begin
                cnt_d = cnt_q + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            grid_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grid_q  <= grid_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.grid_o    = grid_q;
    assign bus.line_o    = grid_q[255:240];
    assign bus.tick_o    = tick_q;
    assign bus.game_over = (state_q == ST_OVER);

`ifdef TUBE_SCORE_EN
    logic [7:0]  score_q, score_d;
    logic [15:0] bird_col_bits;

    // Column BIRD_COL before the shift is column BIRD_COL+1 after it.
    always_comb begin
        bird_col_bits = '0;
        for (int r = 0; r < 16; r++) begin
            bird_col_bits[r] = grid_q[16*r + BIRD_COL];
        end
    end

    always_comb begin
        score_d = score_q;
        if (bus.start) begin
            score_d = '0;
        end else if (tick_due && !collide && (|bird_col_bits) && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign bus.score = score_q;
`else
    assign bus.score = '0;
`endif

endmodule

// File: tb/tb_tube_scroll.sv
module tb_tube_scroll;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    tube_scroll_if bus_if ();

    tube_scroll dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

`ifdef TUBE_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int rel      = 0;

    int         obs_q[$];
    int         exp_q[$];
    logic [15:0] line_exp_q[$];
    logic [7:0]  score_exp_q[$];

    function automatic logic [15:0] col_of(input logic [255:0] g, input int c);
        logic [15:0] res;
        res = '0;
        for (int r = 0; r < 16; r++) res[r] = g[16*r + c];
        return res;
    endfunction

    // One clock: drive happened before, sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        rel++;
        if (bus_if.tick_o) obs_q.push_back(rel);
    endtask

    task automatic do_start();
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        rel = 0;
        obs_q.delete();
    endtask

    task automatic test_reset();
        bus_if.SW1 = 0; bus_if.SW2 = 0; bus_if.start = 0;
        bus_if.col_in = '0; bus_if.bird_row = '0;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (bus_if.grid_o !== '0) begin failures++; $display("FAIL reset_grid got=%h want=0", bus_if.grid_o); end
        checks++; if (bus_if.line_o !== '0) begin failures++; $display("FAIL reset_line got=%h want=0", bus_if.line_o); end
        checks++; if (bus_if.tick_o !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b want=0", bus_if.tick_o); end
        checks++; if (bus_if.game_over !== 1'b0) begin failures++; $display("FAIL reset_over got=%b want=0", bus_if.game_over); end
        checks++; if (bus_if.score !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d want=0", bus_if.score); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rel = 0;
        obs_q.delete();
    endtask

    task automatic test_normal();
        logic [255:0] g_exp;
        bit bad;
        bus_if.col_in = 16'h0183; bus_if.bird_row = 4'd2;
        exp_q = '{8, 16, 24};
        repeat (8) step();
        checks++; if (col_of(bus_if.grid_o, 0) !== 16'h0183) begin failures++; $display("FAIL normal_col0 got=%h want=0183", col_of(bus_if.grid_o, 0)); end
        checks++; if (col_of(bus_if.grid_o, 1) !== 16'h0000) begin failures++; $display("FAIL normal_col1 got=%h want=0000", col_of(bus_if.grid_o, 1)); end
        repeat (16) step();
        g_exp = '0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 3; c++) g_exp[16*r + c] = bus_if.col_in[r];
        checks++; if (bus_if.grid_o !== g_exp) begin failures++; $display("FAIL normal_grid got=%h want=%h", bus_if.grid_o, g_exp); end
        checks++;
        bad = (obs_q.size() != exp_q.size());
        for (int i = 0; i < exp_q.size() && !bad; i++) if (obs_q[i] != exp_q[i]) bad = 1;
        if (bad) begin failures++; $display("FAIL normal_ticks got=%p want=%p", obs_q, exp_q); end
    endtask

    task automatic test_speed();
        logic [1:0] sw_tab [3];
        int         per_tab[3];
        bit bad;
        sw_tab  = '{2'b10, 2'b11, 2'b01};
        per_tab = '{4, 4, 2};
        bus_if.col_in = '0;
        for (int m = 0; m < 3; m++) begin
            {bus_if.SW1, bus_if.SW2} = sw_tab[m];
            do_start();
            exp_q.delete();
            for (int k = 1; k <= 3; k++) exp_q.push_back(k * per_tab[m]);
            repeat (3 * per_tab[m] + 1) step();
            checks++;
            bad = (obs_q.size() != exp_q.size());
            for (int i = 0; i < exp_q.size() && !bad; i++) if (obs_q[i] != exp_q[i]) bad = 1;
            if (bad) begin failures++; $display("FAIL speed_sw%b ticks got=%p want=%p", sw_tab[m], obs_q, exp_q); end
        end
        bus_if.SW1 = 0; bus_if.SW2 = 0;
    endtask

    task automatic test_speed_change();
        bit bad;
        bus_if.SW1 = 0; bus_if.SW2 = 0; bus_if.col_in = '0;
        do_start();
        repeat (5) step();
        bus_if.SW1 = 1;
        repeat (9) step();
        exp_q = '{6, 10, 14};
        checks++;
        bad = (obs_q.size() != exp_q.size());
        for (int i = 0; i < exp_q.size() && !bad; i++) if (obs_q[i] != exp_q[i]) bad = 1;
        if (bad) begin failures++; $display("FAIL speed_change ticks got=%p want=%p", obs_q, exp_q); end
        bus_if.SW1 = 0;
    endtask

    task automatic test_walk();
        int nt, budget;
        logic [15:0] le;
        logic [7:0]  se;
        bus_if.SW1 = 0; bus_if.SW2 = 1; bus_if.bird_row = 4'd3;
        bus_if.col_in = 16'h8000;
        do_start();
        for (int t = 1; t <= 17; t++) begin
            line_exp_q.push_back(t <= 16 ? 16'(1 << (t - 1)) : 16'h0000);
            score_exp_q.push_back((SCORE_EN && t >= 14) ? 8'd1 : 8'd0);
        end
        nt = 0; budget = 0;
        while (line_exp_q.size() > 0 && budget < 100) begin
            step();
            budget++;
            if (bus_if.tick_o) begin
                nt++;
                if (nt == 1) bus_if.col_in = '0;
                le = line_exp_q.pop_front();
                se = score_exp_q.pop_front();
                checks++; if (bus_if.line_o !== le) begin failures++; $display("FAIL walk_line tick=%0d got=%h want=%h", nt, bus_if.line_o, le); end
                checks++; if (bus_if.score !== se) begin failures++; $display("FAIL walk_score tick=%0d got=%0d want=%0d", nt, bus_if.score, se); end
                checks++; if (bus_if.game_over !== 1'b0) begin failures++; $display("FAIL walk_over tick=%0d got=%b want=0", nt, bus_if.game_over); end
            end
        end
        checks++; if (line_exp_q.size() != 0) begin failures++; $display("FAIL walk_timeout ticks_seen=%0d want=17", nt); end
        line_exp_q.delete(); score_exp_q.delete();
    endtask

    task automatic test_collision();
        int nt, budget;
        logic [255:0] g_exp;
        bus_if.SW1 = 0; bus_if.SW2 = 1; bus_if.bird_row = 4'd3;
        bus_if.col_in = 16'h0008;
        do_start();
        nt = 0; budget = 0;
        while (nt < 13 && budget < 100) begin
            step();
            budget++;
            if (bus_if.tick_o) begin
                nt++;
                if (nt == 1) bus_if.col_in = '0;
            end
        end
        g_exp = '0;
        g_exp[3*16 + 12] = 1'b1;
        checks++; if (nt != 13) begin failures++; $display("FAIL coll_timeout ticks=%0d want=13", nt); end
        checks++; if (bus_if.game_over !== 1'b0) begin failures++; $display("FAIL coll_early got=%b want=0", bus_if.game_over); end
        checks++; if (bus_if.grid_o !== g_exp) begin failures++; $display("FAIL coll_grid got=%h want=%h", bus_if.grid_o, g_exp); end
        step();
        checks++; if (bus_if.game_over !== 1'b1) begin failures++; $display("FAIL coll_over got=%b want=1", bus_if.game_over); end
        bus_if.col_in = 16'hFFFF;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (bus_if.grid_o !== g_exp || bus_if.tick_o !== 1'b0 || bus_if.score !== 8'd0 || bus_if.game_over !== 1'b1) begin
                failures++;
                $display("FAIL coll_frozen cyc=%0d got grid=%h tick=%b score=%0d over=%b want grid=%h tick=0 score=0 over=1",
                         i, bus_if.grid_o, bus_if.tick_o, bus_if.score, bus_if.game_over, g_exp);
            end
        end
    endtask

    task automatic test_start_over();
        do_start();
        checks++; if (bus_if.grid_o !== '0) begin failures++; $display("FAIL start_over_grid got=%h want=0", bus_if.grid_o); end
        checks++; if (bus_if.game_over !== 1'b0) begin failures++; $display("FAIL start_over_over got=%b want=0", bus_if.game_over); end
        checks++; if (bus_if.score !== 8'd0) begin failures++; $display("FAIL start_over_score got=%0d want=0", bus_if.score); end
        checks++; if (bus_if.tick_o !== 1'b0) begin failures++; $display("FAIL start_over_tick got=%b want=0", bus_if.tick_o); end
        bus_if.col_in = '0;
    endtask

    task automatic test_start_tick();
        bus_if.SW1 = 0; bus_if.SW2 = 0; bus_if.bird_row = 4'd3;
        bus_if.col_in = 16'hFFFF;
        do_start();
        repeat (7) step();
        do_start();
        checks++; if (bus_if.grid_o !== '0) begin failures++; $display("FAIL start_tick_grid got=%h want=0", bus_if.grid_o); end
        checks++; if (bus_if.tick_o !== 1'b0) begin failures++; $display("FAIL start_tick_tick got=%b want=0", bus_if.tick_o); end
        repeat (9) step();
        checks++; if (obs_q.size() != 1 || obs_q[0] != 8) begin failures++; $display("FAIL start_tick_next got=%p want='{8}", obs_q); end
        checks++; if (col_of(bus_if.grid_o, 0) !== 16'hFFFF) begin failures++; $display("FAIL start_tick_col0 got=%h want=ffff", col_of(bus_if.grid_o, 0)); end
    endtask

    task automatic test_async_reset();
        bit bad;
        bus_if.SW1 = 0; bus_if.SW2 = 0; bus_if.bird_row = 4'd2;
        bus_if.col_in = 16'h0183;
        do_start();
        repeat (11) step();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus_if.grid_o !== '0) begin failures++; $display("FAIL areset_grid got=%h want=0", bus_if.grid_o); end
        checks++;
        if (bus_if.line_o !== '0 || bus_if.tick_o !== 1'b0 || bus_if.game_over !== 1'b0 || bus_if.score !== 8'd0) begin
            failures++;
            $display("FAIL areset_outs got line=%h tick=%b over=%b score=%0d want all 0",
                     bus_if.line_o, bus_if.tick_o, bus_if.game_over, bus_if.score);
        end
        @(negedge clk);
        reset_n = 1'b1;
        rel = 0;
        obs_q.delete();
        repeat (17) step();
        exp_q = '{8, 16};
        checks++;
        bad = (obs_q.size() != exp_q.size());
        for (int i = 0; i < exp_q.size() && !bad; i++) if (obs_q[i] != exp_q[i]) bad = 1;
        if (bad) begin failures++; $display("FAIL areset_ticks got=%p want=%p", obs_q, exp_q); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_speed();
        test_speed_change();
        test_walk();
        test_collision();
        test_start_over();
        test_start_tick();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1);
    end

endmodule
